// File: rtl/handshake_pkg.sv
// Shared types and constants for the full valid/ready register slice.
package handshake_pkg;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } slice_state_t;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/handshake_full_slice.sv
// Full register slice: main + skid entries, every output decoded from state or
// taken straight from a data flop, so both handshake paths are cut.
module handshake_full_slice
  import handshake_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] up_data,
  input  logic              up_valid,
  output logic              up_ready,
  output logic [DATA_W-1:0] down_data,
  output logic              down_valid,
  input  logic              down_ready,
  output logic [1:0]        occupancy
);

  slice_state_t      state, state_nxt;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              load_main_up, load_main_skid, load_skid;
  logic              up_fire, down_fire;

  // Output decode depends on state only; the spare code reads as EMPTY.
  always_comb begin
    up_ready   = 1'b1;
    down_valid = 1'b0;
    occupancy  = OCC_EMPTY;
    case (state)
      S_BUSY: begin
        down_valid = 1'b1;
        occupancy  = OCC_ONE;
      end
      S_FULL: begin
        up_ready   = 1'b0;
        down_valid = 1'b1;
        occupancy  = OCC_TWO;
      end
      default: ;
    endcase
  end

  assign up_fire   = up_valid & up_ready;
  assign down_fire = down_valid & down_ready;
  assign down_data = main_data;

  always_comb begin
    state_nxt      = state;
    load_main_up   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_BUSY: begin
          if (up_fire && down_fire) begin
            load_main_up = 1'b1;
          end else if (up_fire) begin
            load_skid = 1'b1;
            state_nxt = S_FULL;
          end else if (down_fire) begin
            state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (down_fire) begin
            load_main_skid = 1'b1;
            state_nxt      = S_BUSY;
          end
        end
        default: begin
          // EMPTY, or an illegal code recovering as EMPTY
          if (up_fire) begin
            load_main_up = 1'b1;
            state_nxt    = S_BUSY;
          end else begin
            state_nxt = S_EMPTY;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data <= '0;
      skid_data <= '0;
    end else begin
      if (load_main_up)        main_data <= up_data;
      else if (load_main_skid) main_data <= skid_data;
      if (load_skid)           skid_data <= up_data;
    end
  end

endmodule

// File: tb/tb_handshake_full_slice.sv
// Scoreboard bench: a capacity-2 queue model predicts flags and FIFO order.
module tb_handshake_full_slice;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [7:0] up_data;
  logic       up_valid;
  logic       up_ready;
  logic [7:0] down_data;
  logic       down_valid;
  logic       down_ready;
  logic [1:0] occupancy;

  int checks = 0;
  int errors = 0;

  handshake_full_slice #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .up_data(up_data), .up_valid(up_valid), .up_ready(up_ready),
    .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the slice behaves as a 2-deep FIFO whose flags follow its fill level.
  logic [7:0] sb[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall = 1'b0;
      chk("rst_up_ready", {31'b0, up_ready}, 1);
      chk("rst_down_valid", {31'b0, down_valid}, 0);
      chk("rst_occupancy", {30'b0, occupancy}, 0);
    end else begin
      automatic int n  = sb.size();
      automatic bit uf = up_valid && (n < 2);
      automatic bit df = (n > 0) && down_ready;
      chk("up_ready", {31'b0, up_ready}, {31'b0, n < 2});
      chk("down_valid", {31'b0, down_valid}, {31'b0, n > 0});
      chk("occupancy", {30'b0, occupancy}, n);
      if (n > 0) chk("down_data_order", {24'b0, down_data}, {24'b0, sb[0]});
      if (prev_stall && down_valid) chk("stall_stable", {24'b0, down_data}, {24'b0, prev_data});
      prev_stall = down_valid && !down_ready && !flush;
      prev_data  = down_data;
      if (flush) begin
        sb.delete();
      end else begin
        if (df) void'(sb.pop_front());
        if (uf) sb.push_back(up_data);
      end
    end
  end

  always @(posedge clk) begin
    assert (occupancy <= 2'd2) else $error("occupancy out of range");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    up_valid = 1'b1; up_data = 8'hA5; down_ready = 1'b0;
    step(); step();
    chk("hold_rst_up_ready", {31'b0, up_ready}, 1);
    chk("hold_rst_down_valid", {31'b0, down_valid}, 0);
    rst_n = 1'b1;
    step();
    up_valid = 1'b0;
    chk("first_accept_valid", {31'b0, down_valid}, 1);
    chk("first_accept_data", {24'b0, down_data}, 8'hA5);
    down_ready = 1'b1;
    step();

    // back-to-back stream
    up_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      up_data = 8'(i);
      step();
      chk("stream_occ", {30'b0, occupancy}, 1);
    end
    up_valid = 1'b0;
    step(); step();

    // backpressure fills main and skid
    down_ready = 1'b0; up_valid = 1'b1;
    up_data = 8'h20; step();
    up_data = 8'h21; step();
    up_data = 8'h22; step();
    chk("bp_occ", {30'b0, occupancy}, 2);
    chk("bp_up_ready", {31'b0, up_ready}, 0);
    chk("bp_head", {24'b0, down_data}, 8'h20);
    down_ready = 1'b1;
    step();
    chk("bp_drain1", {24'b0, down_data}, 8'h21);
    step();
    up_valid = 1'b0;
    chk("bp_drain2", {24'b0, down_data}, 8'h22);
    step(); step();

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      up_valid   = 1'($urandom_range(0, 1));
      up_data    = 8'($urandom);
      down_ready = 1'($urandom_range(0, 1));
      step();
    end
    up_valid = 1'b0; down_ready = 1'b1;
    step(); step(); step();

    // flush from FULL with upstream still offering
    down_ready = 1'b0; up_valid = 1'b1;
    up_data = 8'h30; step();
    up_data = 8'h31; step();
    chk("pre_flush_occ", {30'b0, occupancy}, 2);
    flush = 1'b1; up_data = 8'h99;
    step();
    flush = 1'b0; up_valid = 1'b0;
    chk("flush_down_valid", {31'b0, down_valid}, 0);
    chk("flush_occ", {30'b0, occupancy}, 0);
    up_valid = 1'b1; up_data = 8'h55;
    step();
    up_valid = 1'b0; down_ready = 1'b1;
    chk("post_flush_data", {24'b0, down_data}, 8'h55);
    chk("post_flush_occ", {30'b0, occupancy}, 1);
    step();
    chk("post_flush_empty", {31'b0, down_valid}, 0);

    // asynchronous reset while FULL
    down_ready = 1'b0; up_valid = 1'b1;
    up_data = 8'h40; step();
    up_data = 8'h41; step();
    chk("pre_areset_occ", {30'b0, occupancy}, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_up_ready", {31'b0, up_ready}, 1);
    chk("areset_down_valid", {31'b0, down_valid}, 0);
    chk("areset_occ", {30'b0, occupancy}, 0);
    chk("areset_data", {24'b0, down_data}, 0);
    up_valid = 1'b0;
    step();
    rst_n = 1'b1;
    up_valid = 1'b1; up_data = 8'h77; down_ready = 1'b1;
    step();
    up_valid = 1'b0;
    chk("after_reset_data", {24'b0, down_data}, 8'h77);
    chk("after_reset_valid", {31'b0, down_valid}, 1);
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
